// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher: one round per clk edge, round keys fetched by key_idx.
// Optional abort input is present when AES_INV_ABORT_EN is defined.
module aes_inv_cipher (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] ct,
  output logic [3:0]   key_idx,
  input  logic [127:0] rk,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [127:0] pt
);

  // state | meaning
  // IDLE  | waiting for start, key 10 presented for the initial AddRoundKey
  // ROUND | full inverse round using key 'round' (9 down to 1)
  // FINAL | last round without InvMixColumns, key 0, loads pt
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

  localparam logic [255:0][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // InvMixColumns row 0 coefficients; later rows are right rotations
  localparam logic [15:0] MIX_CF = 16'hebd9;

  fsm_t         fsm, fsm_d;
  logic [3:0]   round, round_d;
  logic [127:0] state, state_d, pt_d;
  logic         done_d;

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c-r+4)%4)+r)) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = INV_SBOX[~s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] b2, b4, b8;
    b2 = xt(b);
    b4 = xt(b2);
    b8 = xt(b4);
    return (m[0] ? b : 8'h00) ^ (m[1] ? b2 : 8'h00) ^
           (m[2] ? b4 : 8'h00) ^ (m[3] ? b8 : 8'h00);
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(s[8*(15-(4*c+j)) +: 8], MIX_CF[4*(3-((j-r+4)%4)) +: 4]);
        o[8*(15-(4*c+r)) +: 8] = acc;
      end
    return o;
  endfunction

  // Key index decodes registered state only, so it never depends on inputs
  always_comb begin
    key_idx = 4'd10;
    case (fsm)
      ROUND:   key_idx = round;
      FINAL:   key_idx = 4'd0;
      default: key_idx = 4'd10;
    endcase
  end

  assign busy = (fsm != IDLE);

  always_comb begin
    fsm_d   = fsm;
    round_d = round;
    state_d = state;
    pt_d    = pt;
    done_d  = 1'b0;
    case (fsm)
      IDLE: begin
        if (start) begin
          state_d = ct ^ rk;
          round_d = 4'd9;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        state_d = inv_mix_columns(inv_sub_bytes(inv_shift_rows(state)) ^ rk);
        round_d = round - 4'd1;
        if (round == 4'd1) fsm_d = FINAL;
      end
      FINAL: begin
        pt_d   = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
        done_d = 1'b1;
        fsm_d  = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
`ifdef AES_INV_ABORT_EN
    if (abort && fsm != IDLE) begin
      fsm_d   = IDLE;
      round_d = 4'd0;
      state_d = '0;
      pt_d    = pt;
      done_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm   <= IDLE;
      round <= 4'd0;
      state <= '0;
      pt    <= '0;
      done  <= 1'b0;
    end else begin
      fsm   <= fsm_d;
      round <= round_d;
      state <= state_d;
      pt    <= pt_d;
      done  <= done_d;
    end
  end

endmodule
